sound_latch_irq: RTL
====================

# sound_latch_irq

Sound-CPU communication stage for the 68000 → Z80 path. It consumes the 68K `sound_latch_cs` select and the Z80 `z80_latch_r_cs` / `z80_latch_clr_cs` port selects. It holds the command byte the main CPU posts and exposes it to the Z80 on read. It also generates the Z80's periodic maskable interrupt, which is held until an interrupt-acknowledge cycle.

## Interface
- `IRQ_DIV`, default 512: Z80 clock-enable pulses per interrupt period; legal range 2..65535.
- `FIFO_DEPTH`, default 4: command queue depth when `SOUND_LATCH_FIFO_EN` is defined; power of two, 2..16; ignored otherwise.

Ports:
- `clk_sys`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `m68k_din`  in  16  68K write data; only bits [7:0] are used.
- `m68k_rw`  in  1  68K read/write; 1 = read.
- `m68k_lds_n`  in  1  68K lower data strobe, active low.
- `sound_latch_cs`  in  1  68K select for the command latch.
- `z80_cen`  in  1  Z80 clock enable; one `clk_sys` cycle wide.
- `z80_rd_n`  in  1  Z80 read strobe.
- `z80_wr_n`  in  1  Z80 write strobe.
- `z80_m1_n`  in  1  Z80 M1.
- `z80_iorq_n`  in  1  Z80 IORQ.
- `z80_latch_r_cs`  in  1  Z80 I/O select, port 0x06 (read latch).
- `z80_latch_clr_cs`  in  1  Z80 I/O select, port 0x04 (clear latch).
- `latch_dout`  out  8  current command byte; 0x00 when nothing is held.
- `latch_pending`  out  1  1 while a command is held and not yet cleared.
- `z80_irq_n`  out  1  Z80 INT, active low.

## Operation
- Write request: `wr_req = sound_latch_cs & ~m68k_rw & ~m68k_lds_n`.
  - A write strobe is the rising edge of `wr_req` against its one-cycle-delayed copy.
  - Each 68K bus cycle therefore produces exactly one capture, however long the select is held.
- Clear request: `clr_req = z80_latch_clr_cs & ~z80_wr_n`; its strobe is the rising edge, detected the same way.
- Read path: `latch_dout` is a registered value and is always valid. The Z80 read (`z80_latch_r_cs & ~z80_rd_n`) is side-effect free; the Z80 data mux samples `latch_dout` directly.
- Single-register mode (macro absent):
  - Write strobe: latch ← `m68k_din[7:0]`, pending ← 1. A second write before a clear overwrites the latch.
  - Clear strobe: latch ← 0x00, pending ← 0.
  - Write and clear strobes in the same cycle: the write wins (new data captured, pending = 1).
- IRQ generator:
  - A 16-bit counter increments on each `z80_cen`. On reaching `IRQ_DIV-1` with `z80_cen` high, it wraps to 0 and sets the interrupt (`z80_irq_n` ← 0).
  - Acknowledge is `~z80_m1_n & ~z80_iorq_n`, sampled every `clk_sys`. It releases the interrupt (`z80_irq_n` ← 1).
  - A period tick arriving while the interrupt is still asserted is absorbed; ticks are not queued.
  - Tick and acknowledge in the same cycle: the tick wins, so `z80_irq_n` stays 0.
- Reset values: counter 0, `z80_irq_n` = 1, `latch_dout` = 0x00, `latch_pending` = 0, edge-detect registers 0, queue empty. Asserting reset mid-operation discards all held commands.

## Timing
- Capture latency: `latch_dout` / `latch_pending` change on the `clk_sys` edge that samples the `wr_req` rising edge, so they are visible 1 cycle after `wr_req` first goes high.
- Clear latency: 1 cycle after `clr_req` first goes high.
- IRQ assertion: on the edge where `z80_cen` = 1 and counter = `IRQ_DIV-1`, so `z80_irq_n` is low from the next cycle.
  - First IRQ after reset comes exactly `IRQ_DIV` `z80_cen` pulses after reset release.
  - Period is exactly `IRQ_DIV` `z80_cen` pulses, independent of acknowledge timing.
- IRQ release: `z80_irq_n` is high 1 cycle after the acknowledge is first sampled.
- No combinational path from any input to any output.

## Configuration
- `SOUND_LATCH_FIFO_EN` defined: commands are held in a `FIFO_DEPTH`-entry queue.
  - Write strobe pushes; clear strobe pops.
  - `latch_dout` = head entry, or 0x00 when the queue is empty; `latch_pending` = queue not empty.
  - Write to a full queue: the byte is dropped and the queue is unchanged.
  - Clear on an empty queue: no effect.
  - Simultaneous push and pop on a non-empty, non-full queue: both take effect, so the count is unchanged and the head advances.
  - Simultaneous push and pop on an empty queue: after the cycle the queue holds the pushed byte.
  - Simultaneous push and pop on a full queue: the pop is performed, then the push is accepted.
- `SOUND_LATCH_FIFO_EN` undefined: single-register behaviour as described in Operation.

## Test plan
- Reset, then hold `sound_latch_cs` with a write for 6 cycles, `m68k_din` = 0x12A5 → one capture; `latch_dout` = 0xA5 and `latch_pending` = 1 from cycle 1; no further change.
- Write 0x11, then 0x22, then a Z80 clear pulse:
  - Single mode: dout 0x22, then 0x00 / pending 0.
  - FIFO mode: dout 0x11, then 0x22 after the clear, pending still 1.
- Write strobe and clear strobe in the same cycle with data 0x3C:
  - Single mode: dout 0x3C, pending 1.
  - FIFO mode from empty: dout 0x3C, count 1.
- `IRQ_DIV` = 4, `z80_cen` every 2nd cycle → `z80_irq_n` falls every 8 cycles; an acknowledge 3 cycles after assertion raises it 1 cycle later; with no acknowledge, it stays low across later ticks.
- FIFO mode, depth 4: push 5 bytes 0x01..0x05, then pop 4 times → dout sequence 0x01, 0x02, 0x03, 0x04, 0x00; 0x05 is dropped; pending 0 at the end.
- Assert reset with 2 entries queued and IRQ pending → next cycle: dout 0x00, pending 0, `z80_irq_n` = 1, counter restarts from 0.

Source files
------------

// File: rtl/sound_latch_irq.sv
// 68000 -> Z80 sound command latch and periodic Z80 interrupt generator.
// Define SOUND_LATCH_FIFO_EN to hold commands in a FIFO_DEPTH-entry queue instead of one register.
module sound_latch_irq #(
  parameter int IRQ_DIV    = 512,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] m68k_din,
  input  logic        m68k_rw,
  input  logic        m68k_lds_n,
  input  logic        sound_latch_cs,
  input  logic        z80_cen,
  input  logic        z80_rd_n,
  input  logic        z80_wr_n,
  input  logic        z80_m1_n,
  input  logic        z80_iorq_n,
  input  logic        z80_latch_r_cs,
  input  logic        z80_latch_clr_cs,
  output logic [7:0]  latch_dout,
  output logic        latch_pending,
  output logic        z80_irq_n
);

  // Strobes fire once per bus cycle: the rising edge of each level request
  // against its one-cycle-delayed copy, however long the select is held.
  logic w_wr_req;
  logic w_clr_req;
  logic w_wr_stb;
  logic w_clr_stb;
  logic w_ack;
  logic w_tick;
  logic w_rd_req;
  logic w_unused_ok;
  logic r_wr_req_d;
  logic r_clr_req_d;
  logic [15:0] r_irq_cnt;
  logic r_irq_n;

  assign w_wr_req  = sound_latch_cs & ~m68k_rw & ~m68k_lds_n;
  assign w_clr_req = z80_latch_clr_cs & ~z80_wr_n;
  assign w_wr_stb  = w_wr_req & ~r_wr_req_d;
  assign w_clr_stb = w_clr_req & ~r_clr_req_d;
  assign w_ack     = ~z80_m1_n & ~z80_iorq_n;
  assign w_tick    = z80_cen & (r_irq_cnt == 16'(IRQ_DIV - 1));

  // Z80 reads have no side effect; its data mux samples latch_dout directly.
  assign w_rd_req  = z80_latch_r_cs & ~z80_rd_n;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wr_req_d  <= 1'b0;
      r_clr_req_d <= 1'b0;
    end else begin
      r_wr_req_d  <= w_wr_req;
      r_clr_req_d <= w_clr_req;
    end
  end

  // Tick beats acknowledge; a tick while already asserted is simply absorbed.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_irq_cnt <= 16'd0;
      r_irq_n   <= 1'b1;
    end else begin
      if (z80_cen) r_irq_cnt <= w_tick ? 16'd0 : r_irq_cnt + 16'd1;
      if (w_tick)     r_irq_n <= 1'b0;
      else if (w_ack) r_irq_n <= 1'b1;
    end
  end

  assign z80_irq_n = r_irq_n;

`ifdef SOUND_LATCH_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  // A full queue still accepts a push when a pop frees the head slot in the same cycle.
  assign w_pop  = w_clr_stb & (r_count != '0);
  assign w_push = w_wr_stb & ((r_count != CW'(FIFO_DEPTH)) | w_pop);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_push) r_mem[r_wr_ptr] <= m68k_din[7:0];
  end

  assign latch_pending = (r_count != '0);
  assign latch_dout    = latch_pending ? r_mem[r_rd_ptr] : 8'h00;
  assign w_unused_ok   = ^{m68k_din[15:8], w_rd_req};
`else
  logic [7:0] r_latch;
  logic       r_pending;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_latch   <= 8'h00;
      r_pending <= 1'b0;
    end else if (w_wr_stb) begin
      r_latch   <= m68k_din[7:0];
      r_pending <= 1'b1;
    end else if (w_clr_stb) begin
      r_latch   <= 8'h00;
      r_pending <= 1'b0;
    end
  end

  assign latch_dout    = r_latch;
  assign latch_pending = r_pending;
  assign w_unused_ok   = ^{m68k_din[15:8], w_rd_req, FIFO_DEPTH[0]};
`endif

endmodule
